// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer for the nonpipelined LEGv8 core: steps each
// instruction through FETCH/DECODE/EXECUTE/[MEMORY]/WRITEBACK and gates strobes.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               imem_ready,
  input  logic               dmem_ready,
  input  logic               ctl_mem_read,
  input  logic               ctl_mem_write,
  input  logic               ctl_reg_write,
  input  logic               ctl_update_sreg,
  input  logic [2:0]         ctl_branch_op,
  input  logic               branch_taken,
  input  logic               halt_req,
  output logic               imem_req,
  output logic               ir_load,
  output logic               dmem_read_req,
  output logic               dmem_write_req,
  output logic               sreg_write_en,
  output logic               reg_write_en,
  output logic               pc_write,
  output logic               pc_src,
  output logic               busy,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count,
  output logic               timeout_err
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEMORY    = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5,
    S_ERROR     = 3'd6
  } state_t;

  localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

  state_t     st, st_nxt;
  logic [7:0] wait_cnt, wait_nxt, wait_inc;
  logic       take_q;

  assign state    = st;
  assign wait_inc = wait_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_FETCH;
      wait_cnt    <= '0;
      take_q      <= 1'b0;
      instr_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      st       <= st_nxt;
      wait_cnt <= wait_nxt;
      if (st == S_EXECUTE)
        take_q <= branch_taken && (ctl_branch_op != 3'b000);
      if (st == S_WRITEBACK)
        instr_count <= instr_count + COUNT_W'(1);
      if (st_nxt == S_ERROR)
        timeout_err <= 1'b1;
    end
  end

  // Ready is tested before the timeout so a late ready still wins.
  always_comb begin
    st_nxt         = st;
    wait_nxt       = wait_cnt;
    imem_req       = 1'b0;
    ir_load        = 1'b0;
    dmem_read_req  = 1'b0;
    dmem_write_req = 1'b0;
    sreg_write_en  = 1'b0;
    reg_write_en   = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    busy           = 1'b1;
    case (st)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load  = !reset;
          st_nxt   = S_DECODE;
          wait_nxt = '0;
        end else if (wait_inc == TMO) begin
          st_nxt   = S_ERROR;
          wait_nxt = '0;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      S_DECODE: st_nxt = S_EXECUTE;
      S_EXECUTE: begin
        sreg_write_en = ctl_update_sreg;
        if (ctl_mem_read && ctl_mem_write) st_nxt = S_ERROR;
        else if (ctl_mem_read || ctl_mem_write) st_nxt = S_MEMORY;
        else st_nxt = S_WRITEBACK;
      end
      S_MEMORY: begin
        dmem_read_req  = ctl_mem_read;
        dmem_write_req = ctl_mem_write;
        if (dmem_ready) begin
          st_nxt   = S_WRITEBACK;
          wait_nxt = '0;
        end else if (wait_inc == TMO) begin
          st_nxt   = S_ERROR;
          wait_nxt = '0;
        end else begin
          wait_nxt = wait_inc;
        end
      end
      S_WRITEBACK: begin
        reg_write_en = ctl_reg_write;
        pc_write     = 1'b1;
        pc_src       = take_q;
        st_nxt       = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:  busy = 1'b0;
      S_ERROR: busy = 1'b0;
      default: st_nxt = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: retire expectations are queued per
// instruction and consumed by a writeback monitor.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready, dmem_ready;
  logic        ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_update_sreg;
  logic [2:0]  ctl_branch_op;
  logic        branch_taken, halt_req;
  logic        imem_req, ir_load, dmem_read_req, dmem_write_req;
  logic        sreg_write_en, reg_write_en, pc_write, pc_src, busy;
  logic [2:0]  state;
  logic [31:0] instr_count;
  logic        timeout_err;

  typedef struct {
    logic        rw;
    logic        src;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] model_cnt = 0;

  always #5 clk = ~clk;

  multicycle_sequencer #(.MEM_TIMEOUT(15), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write),
    .ctl_reg_write(ctl_reg_write), .ctl_update_sreg(ctl_update_sreg),
    .ctl_branch_op(ctl_branch_op), .branch_taken(branch_taken),
    .halt_req(halt_req),
    .imem_req(imem_req), .ir_load(ir_load),
    .dmem_read_req(dmem_read_req), .dmem_write_req(dmem_write_req),
    .sreg_write_en(sreg_write_en), .reg_write_en(reg_write_en),
    .pc_write(pc_write), .pc_src(pc_src), .busy(busy),
    .state(state), .instr_count(instr_count), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {imem_req, ir_load, dmem_read_req, dmem_write_req,
            sreg_write_en, reg_write_en, pc_write, pc_src};
  endfunction

  // Writeback monitor: every retire must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!reset && pc_write) begin
      if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("wb_rw",  {31'd0, reg_write_en}, {31'd0, mon_e.rw});
        chk("wb_src", {31'd0, pc_src},       {31'd0, mon_e.src});
        chk("wb_cnt", instr_count,           mon_e.cnt);
      end
    end
  end

  task automatic idle_inputs();
    imem_ready = 0; dmem_ready = 0; halt_req = 0;
    ctl_mem_read = 0; ctl_mem_write = 0; ctl_reg_write = 0; ctl_update_sreg = 0;
    ctl_branch_op = 3'b000; branch_taken = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    sb.delete();
    model_cnt = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Drives one instruction; fw/mw = wait cycles before fetch/data ready.
  // hmode: 0 no halt, 1 halt only outside writeback, 2 halt throughout.
  task automatic do_instr(input logic rd, input logic wr, input logic rw, input logic us,
                          input logic [2:0] bop, input logic bt,
                          input int fw, input int mw, input int hmode);
    exp_t e;
    logic take;
    int   n;
    take  = bt && (bop != 3'b000);
    e.rw  = rw; e.src = take; e.cnt = model_cnt;
    sb.push_back(e);
    model_cnt++;
    ctl_mem_read = rd; ctl_mem_write = wr; ctl_reg_write = rw;
    ctl_update_sreg = us; ctl_branch_op = bop; branch_taken = bt;
    n = fw + 3 + ((rd || wr) ? mw + 1 : 0) + 1;
    for (int i = 0; i < n; i++) begin
      logic [2:0] es;
      logic [7:0] ev;
      imem_ready = 0; dmem_ready = 0;
      if (i <= fw) begin
        es = 3'd0; imem_ready = (i == fw); ev = {1'b1, (i == fw), 6'b0};
      end else if (i == fw + 1) begin
        es = 3'd1; ev = 8'h00;
      end else if (i == fw + 2) begin
        es = 3'd2; ev = {4'b0, us, 3'b0};
      end else if (i < n - 1) begin
        es = 3'd3; dmem_ready = ((i - fw - 3) == mw); ev = {2'b0, rd, wr, 4'b0};
      end else begin
        es = 3'd4; ev = {5'b0, rw, 1'b1, take};
      end
      halt_req = (hmode == 2) || (hmode == 1 && es != 3'd4);
      @(negedge clk);
      chk("state", {29'd0, state}, {29'd0, es});
      chk("strobes", {24'd0, strobes()}, {24'd0, ev});
      @(posedge clk); #1;
    end
    imem_ready = 0; dmem_ready = 0; halt_req = 0;
    chk("count", instr_count, model_cnt);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    imem_ready = 1'b1;
    @(negedge clk);
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_strobes", {24'd0, strobes()}, 32'h80);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_err", {31'd0, timeout_err}, 32'd0);

    // ADD, load with 3 data wait states (halt ignored), CBZ taken + halt
    do_reset();
    do_instr(0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    do_instr(1, 0, 1, 0, 3'b000, 0, 0, 3, 1);
    do_instr(0, 0, 0, 1, 3'b011, 1, 0, 0, 2);
    @(negedge clk);
    chk("halt_state", {29'd0, state}, 32'd5);
    chk("halt_busy", {31'd0, busy}, 32'd0);
    chk("halt_count", instr_count, 32'd3);
    chk("halt_strobes", {24'd0, strobes()}, 32'd0);
    imem_ready = 1;
    repeat (3) @(negedge clk);
    chk("halt_stay", {29'd0, state}, 32'd5);
    imem_ready = 0;

    // Fetch ready on the last allowed cycle, store, untaken-kind branch, sub
    do_reset();
    do_instr(0, 1, 0, 0, 3'b000, 0, 14, 0, 0);
    do_instr(0, 0, 0, 0, 3'b000, 1, 2, 0, 0);
    do_instr(0, 0, 1, 1, 3'b000, 0, 0, 0, 0);
    do_instr(0, 1, 0, 0, 3'b101, 1, 0, 14, 0);

    // Fetch timeout
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("tmo_fetch", {29'd0, state}, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("tmo_state", {29'd0, state}, 32'd6);
    chk("tmo_err", {31'd0, timeout_err}, 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_imem_req", {31'd0, imem_req}, 32'd0);
    imem_ready = 1;
    repeat (4) @(negedge clk);
    chk("tmo_stay", {29'd0, state}, 32'd6);
    chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);

    // Data memory timeout on a store
    do_reset();
    ctl_mem_write = 1; imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dtmo_pre", {29'd0, state}, i);
      @(posedge clk); #1;
      imem_ready = 0;
    end
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("dtmo_wreq", {31'd0, dmem_write_req}, 32'd1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("dtmo_state", {29'd0, state}, 32'd6);
    chk("dtmo_wreq_off", {31'd0, dmem_write_req}, 32'd0);
    chk("dtmo_err", {31'd0, timeout_err}, 32'd1);

    // Illegal read+write: straight to ERROR, no data request
    do_reset();
    ctl_mem_read = 1; ctl_mem_write = 1; imem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("ill_state", {29'd0, state}, (i < 3) ? i : 6);
      chk("ill_dreq", {30'd0, dmem_read_req, dmem_write_req}, 32'd0);
      @(posedge clk); #1;
      imem_ready = 0;
    end
    chk("ill_err", {31'd0, timeout_err}, 32'd1);

    // Reset mid-MEMORY drops requests at once
    do_reset();
    do_instr(0, 0, 1, 0, 3'b000, 0, 0, 0, 0);
    ctl_mem_read = 1; imem_ready = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rmid_state", {29'd0, state}, (i < 3) ? i : 3);
      @(posedge clk); #1;
      imem_ready = 0;
    end
    chk("rmid_rreq_pre", {31'd0, dmem_read_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rmid_state_rst", {29'd0, state}, 32'd0);
    chk("rmid_rreq_rst", {31'd0, dmem_read_req}, 32'd0);
    chk("rmid_count_rst", instr_count, 32'd0);
    chk("rmid_busy_rst", {31'd0, busy}, 32'd1);
    do_reset();

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
